// File: rtl/nco_nch.sv
// nco_nch: NCH-channel quadrature NCO for one spectrogram row.
// A sample tick (EN) starts a sweep that issues one channel per cycle. Each issue reads that
// channel's phase accumulator, advances it by the channel's frequency word, and sends the
// phase through a three-stage quarter-wave table pipeline to the cos/sin outputs.
module nco_nch #(
   parameter int unsigned NCH  = 8,
   parameter int unsigned W    = 18,
   parameter int unsigned PW   = 24,
   parameter int unsigned LW   = 10,
   parameter int unsigned FSH0 = 10
) (
   input  logic                       CK,
   input  logic                       RSTn,
   input  logic                       START,
   input  logic                       EN,
   input  logic [8:0]                 v_pos,
   input  logic                       mode_4800,
   output logic                       busy,
   output logic                       valid,
   output logic [$clog2(NCH)-1:0]     ch,
   output logic signed [W-1:0]        cos,
   output logic signed [W-1:0]        sin,
   output logic                       overrun
);

   localparam int unsigned CW = $clog2(NCH);
   localparam int unsigned QN = 2 ** (LW - 2);  // points per quadrant
   localparam int unsigned AW = LW - 1;         // table index width, covers 0..QN
   localparam int unsigned TW = W - 1;          // table entries are non-negative magnitudes
   localparam real         PI = 3.14159265358979323846;
   localparam real         AMP = real'((2 ** (W - 1)) - 1);

   // Quarter-wave sine table, QN+1 entries so that both 0 and pi/2 are stored exactly.
   function automatic logic [(QN+1)*TW-1:0] gen_rom();
      logic [(QN+1)*TW-1:0] v;
      real                  x;
      v = '0;
      for (int i = 0; i <= int'(QN); i++) begin
         x = AMP * $sin(PI * real'(i) / real'(2 * QN));
         v[i*TW +: TW] = TW'($rtoi($floor(x + 0.5)));
      end
      return v;
   endfunction

   localparam logic [(QN+1)*TW-1:0] ROM = gen_rom();

   function automatic logic [TW-1:0] rom_rd(input logic [AW-1:0] idx);
      return ROM[32'(idx) * TW +: TW];
   endfunction

   typedef enum logic {StIdle, StRun} state_e;

   state_e                      r_state, w_state_d;
   logic [CW-1:0]               r_cnt;
   logic [8:0]                  r_vpos;
   logic                        r_mode;
   logic                        r_ovr;
   logic [NCH-1:0][PW-1:0]      r_phase;
   logic [NCH-1:0][PW-1:0]      w_phase_d;
   logic                        w_issue, w_last;
   logic [PW-1:0]               w_ph, w_base, w_fw;
   logic [LW-1:0]               w_addr;

   logic                        r1_vld;
   logic [CW-1:0]               r1_ch;
   logic [1:0]                  r1_quad;
   logic [AW-1:0]               r1_ia, r1_ib;

   logic                        r2_vld;
   logic [CW-1:0]               r2_ch;
   logic [1:0]                  r2_quad;
   logic [TW-1:0]               r2_sa, r2_sb;

   logic signed [W-1:0]         w_a, w_b, w_cos_d, w_sin_d;
   logic                        r_valid;
   logic [CW-1:0]               r_ch;
   logic signed [W-1:0]         r_cos, r_sin;

   // Sweep state register
   always_ff @(posedge CK) begin
      if (!RSTn) r_state <= StIdle;
      else       r_state <= w_state_d;
   end

   // Sweep next-state: START aborts, last channel ends the sweep
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (EN && !START) w_state_d = StRun;
         StRun:   if (START || w_last) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Sweep outputs: issue strobe and busy flag
   always_comb begin
      w_issue = (r_state == StRun);
      w_last  = w_issue && (r_cnt == CW'(NCH - 1));
      busy    = w_issue;
   end

   // Channel counter; NCH is a power of two so it wraps to 0 after the last issue
   always_ff @(posedge CK) begin
      if (!RSTn)                              r_cnt <= '0;
      else if (START || r_state == StIdle)    r_cnt <= '0;
      else                                    r_cnt <= r_cnt + CW'(1);
   end

   // Row/mode latch and sticky overrun flag
   always_ff @(posedge CK) begin
      if (!RSTn) begin
         r_vpos <= '0;
         r_mode <= 1'b0;
         r_ovr  <= 1'b0;
      end else if (START) begin
         r_vpos <= v_pos;
         r_mode <= mode_4800;
         r_ovr  <= 1'b0;
      end else if (EN && busy) begin
         r_ovr  <= 1'b1;
      end
   end

   // Frequency word of the channel being issued and its phase advance
   always_comb begin
      w_ph      = r_phase[r_cnt];
      w_base    = (PW'(r_vpos) << CW) + PW'(r_cnt) + PW'(1);
      w_fw      = r_mode ? (w_base << (FSH0 + 1)) : (w_base << FSH0);
      w_addr    = w_ph[PW-1 -: LW];
      w_phase_d = r_phase;
      if (w_issue) w_phase_d[r_cnt] = w_ph + w_fw;
   end

   // Phase accumulators, cleared together on START
   always_ff @(posedge CK) begin
      if (!RSTn || START) r_phase <= '0;
      else                r_phase <= w_phase_d;
   end

   // Stage 1: split the table address into quadrant and the two folded indices
   always_ff @(posedge CK) begin
      if (!RSTn) begin
         r1_vld  <= 1'b0;
         r1_ch   <= '0;
         r1_quad <= '0;
         r1_ia   <= '0;
         r1_ib   <= '0;
      end else begin
         r1_vld  <= w_issue && !START;
         r1_ch   <= r_cnt;
         r1_quad <= w_addr[LW-1:LW-2];
         r1_ia   <= AW'(w_addr[LW-3:0]);
         r1_ib   <= AW'(QN) - AW'(w_addr[LW-3:0]);
      end
   end

   // Stage 2: table lookups for sin(phi) and cos(phi) within the quadrant
   always_ff @(posedge CK) begin
      if (!RSTn) begin
         r2_vld  <= 1'b0;
         r2_ch   <= '0;
         r2_quad <= '0;
         r2_sa   <= '0;
         r2_sb   <= '0;
      end else begin
         r2_vld  <= r1_vld && !START;
         r2_ch   <= r1_ch;
         r2_quad <= r1_quad;
         r2_sa   <= rom_rd(r1_ia);
         r2_sb   <= rom_rd(r1_ib);
      end
   end

   // Quadrant folding: rotate and negate the first-quadrant pair
   always_comb begin
      w_a     = $signed({1'b0, r2_sa});
      w_b     = $signed({1'b0, r2_sb});
      w_cos_d = w_b;
      w_sin_d = w_a;
      unique case (r2_quad)
         2'd0: begin w_cos_d = w_b;  w_sin_d = w_a;  end
         2'd1: begin w_cos_d = -w_a; w_sin_d = w_b;  end
         2'd2: begin w_cos_d = -w_b; w_sin_d = -w_a; end
         2'd3: begin w_cos_d = w_a;  w_sin_d = -w_b; end
      endcase
   end

   // Stage 3: output registers; data holds while valid is low
   always_ff @(posedge CK) begin
      if (!RSTn) begin
         r_valid <= 1'b0;
         r_ch    <= '0;
         r_cos   <= '0;
         r_sin   <= '0;
      end else begin
         r_valid <= r2_vld && !START;
         if (r2_vld && !START) begin
            r_ch  <= r2_ch;
            r_cos <= w_cos_d;
            r_sin <= w_sin_d;
         end
      end
   end

   assign valid   = r_valid;
   assign ch      = r_ch;
   assign cos     = r_cos;
   assign sin     = r_sin;
   assign overrun = r_ovr;

endmodule
